jtag_tap_multi: RTL

//  IEEE 1149.1 TAP with an internal 16-state controller and NUM_USER user data channels.

---
 rtl/jtag_tap_multi_if.sv | 23 ++
 rtl/jtag_tap_multi.sv | 126 ++++++++++++
 2 files changed

// File: rtl/jtag_tap_multi_if.sv
// Pin-side and user-side signals of the multi-channel JTAG TAP; tck/trst stay plain ports.
interface jtag_tap_multi_if #(
   parameter int NUM_USER = 4,
   parameter int USER_LEN = 32
);
   logic                         tms;
   logic                         tdi;
   logic                         tdo;
   logic                         tdo_oe;
   logic [NUM_USER*USER_LEN-1:0] user_data_in;
   logic [NUM_USER*USER_LEN-1:0] user_data_out;
   logic [NUM_USER-1:0]          user_capture;
   logic [NUM_USER-1:0]          user_update;

   modport master (
      output tms, tdi, user_data_in,
      input  tdo, tdo_oe, user_data_out, user_capture, user_update
   );
   modport slave (
      input  tms, tdi, user_data_in,
      output tdo, tdo_oe, user_data_out, user_capture, user_update
   );
endinterface

// File: rtl/jtag_tap_multi.sv
// IEEE 1149.1 TAP: 16-state controller, shadowed IR, IDCODE/BYPASS and NUM_USER user DR channels.
module jtag_tap_multi #(
   parameter int                IR_LEN       = 4,
   parameter logic [3:0]        ID_PARTVER   = 4'h0,
   parameter logic [15:0]       ID_PARTNUM   = 16'h0,
   parameter logic [10:0]       ID_MANF      = 11'h0,
   parameter int                NUM_USER     = 4,
   parameter int                USER_LEN     = 32,
   parameter logic [IR_LEN-1:0] USER_BASE_OP = {1'b1, {(IR_LEN-1){1'b0}}}
) (
   input  logic             tck,
   input  logic             trst,
   jtag_tap_multi_if.slave  jif
);
   localparam logic [IR_LEN-1:0] IDCODE_OP = {{(IR_LEN-1){1'b1}}, 1'b0};
   localparam int DR_W  = (USER_LEN > 32) ? USER_LEN : 32;
   localparam int IDX_W = $clog2(DR_W);

   typedef enum logic [3:0] {
      TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PADR, EX2DR, UPDR,
      SELIR, CAPIR, SHIR, EX1IR, PAIR, EX2IR, UPIR
   } state_t;

   state_t                             state, state_nx;
   logic [IR_LEN-1:0]                  ir, ir_sr;
   logic [DR_W-1:0]                    dr_sr, dr_shift, cap_val;
   logic [IDX_W-1:0]                   dr_msb;
   logic [NUM_USER-1:0]                sel, upd;
   logic [NUM_USER-1:0][USER_LEN-1:0]  uout;
   logic                               tdo_q, oe_q;

   always_ff @(posedge tck or negedge trst) begin
      if (!trst) state <= TLR;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         TLR:   state_nx = jif.tms ? TLR   : RTI;
         RTI:   state_nx = jif.tms ? SELDR : RTI;
         SELDR: state_nx = jif.tms ? SELIR : CAPDR;
         CAPDR: state_nx = jif.tms ? EX1DR : SHDR;
         SHDR:  state_nx = jif.tms ? EX1DR : SHDR;
         EX1DR: state_nx = jif.tms ? UPDR  : PADR;
         PADR:  state_nx = jif.tms ? EX2DR : PADR;
         EX2DR: state_nx = jif.tms ? UPDR  : SHDR;
         UPDR:  state_nx = jif.tms ? SELDR : RTI;
         SELIR: state_nx = jif.tms ? TLR   : CAPIR;
         CAPIR: state_nx = jif.tms ? EX1IR : SHIR;
         SHIR:  state_nx = jif.tms ? EX1IR : SHIR;
         EX1IR: state_nx = jif.tms ? UPIR  : PAIR;
         PAIR:  state_nx = jif.tms ? EX2IR : PAIR;
         EX2IR: state_nx = jif.tms ? UPIR  : SHIR;
         UPIR:  state_nx = jif.tms ? SELDR : RTI;
         default: state_nx = TLR;
      endcase
   end

   // Channel opcodes sit below IDCODE_OP, so at most one select bit is ever set.
   for (genvar k = 0; k < NUM_USER; k++) begin : g_sel
      assign sel[k] = (ir == IR_LEN'(USER_BASE_OP + k));
   end

   always_comb begin
      cap_val = '0;
      dr_msb  = '0;
      if (ir == IDCODE_OP) begin
         cap_val = DR_W'({ID_PARTVER, ID_PARTNUM, ID_MANF, 1'b1});
         dr_msb  = IDX_W'(31);
      end else if (|sel) begin
         dr_msb = IDX_W'(USER_LEN-1);
         for (int k = 0; k < NUM_USER; k++)
            if (sel[k]) cap_val = DR_W'(jif.user_data_in[k*USER_LEN +: USER_LEN]);
      end
      // One shared register; tdi lands at the top of whichever length is selected.
      dr_shift         = dr_sr >> 1;
      dr_shift[dr_msb] = jif.tdi;
   end

   always_ff @(posedge tck or negedge trst) begin
      if (!trst) begin
         ir_sr <= '0;
         ir    <= IDCODE_OP;
      end else begin
         if (state == CAPIR)     ir_sr <= IR_LEN'(1);
         else if (state == SHIR) ir_sr <= {jif.tdi, ir_sr[IR_LEN-1:1]};
         if (state == TLR)       ir <= IDCODE_OP;
         else if (state == UPIR) ir <= ir_sr;
      end
   end

   always_ff @(posedge tck or negedge trst) begin
      if (!trst)              dr_sr <= '0;
      else if (state == CAPDR) dr_sr <= cap_val;
      else if (state == SHDR)  dr_sr <= dr_shift;
   end

   always_ff @(posedge tck or negedge trst) begin
      if (!trst) begin
         uout <= '0;
         upd  <= '0;
      end else begin
         upd <= (state == UPDR) ? sel : '0;
         for (int k = 0; k < NUM_USER; k++)
            if (state == UPDR && sel[k]) uout[k] <= dr_sr[USER_LEN-1:0];
      end
   end

   always_ff @(negedge tck or negedge trst) begin
      if (!trst) begin
         tdo_q <= 1'b0;
         oe_q  <= 1'b0;
      end else begin
         oe_q  <= (state == SHIR) || (state == SHDR);
         tdo_q <= (state == SHIR) ? ir_sr[0] :
                  (state == SHDR) ? dr_sr[0] : 1'b0;
      end
   end

   assign jif.tdo           = tdo_q;
   assign jif.tdo_oe        = oe_q;
   assign jif.user_capture  = (state == CAPDR) ? sel : '0;
   assign jif.user_update   = upd;
   assign jif.user_data_out = uout;
endmodule
